// File: rtl/fa_vector_checker_if.sv
// Bus between the full-adder checker and the adder under test.
// The checker drives the operands and receives the sum and carry back.
interface fa_vector_checker_if;
  logic a_o;
  logic b_o;
  logic cin_o;
  logic s_i;
  logic cout_i;

  modport master (
    output a_o, b_o, cin_o,
    input  s_i, cout_i
  );

  modport slave (
    input  a_o, b_o, cin_o,
    output s_i, cout_i
  );
endinterface

// File: rtl/fa_vector_checker.sv
// Hardware-resident exhaustive tester for a one-bit full adder.
// Steps through all eight {A,B,Cin} vectors. Each vector is held for
// SETTLE_CYCLES cycles, and the adder's response is checked on the last
// edge of that window. Reports a saturating error count, the first
// failing vector and a pass flag.
module fa_vector_checker #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned ERR_W         = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  fa_vector_checker_if.master    bus,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [ERR_W-1:0]       err_count,
  output logic                   fail_valid,
  output logic [2:0]             first_fail_idx
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam logic [3:0] HOLD_LAST = 4'(SETTLE_CYCLES - 1);

  state_t           state;
  state_t           state_next;
  logic [2:0]       idx;
  logic [3:0]       hold;
  logic             accept;
  logic             sample;
  logic             last_vec;
  logic             exp_s;
  logic             exp_c;
  logic             mismatch;
  logic [ERR_W-1:0] err_next;

  // Decode run control, the expected adder response and the next state
  always_comb begin
    accept     = start && (state != RUN);
    sample     = (state == RUN) && (hold == HOLD_LAST);
    last_vec   = (idx == 3'd7);
    exp_s      = idx[2] ^ idx[1] ^ idx[0];
    exp_c      = (idx[2] & idx[1]) | (idx[2] & idx[0]) | (idx[1] & idx[0]);
    mismatch   = (bus.s_i != exp_s) || (bus.cout_i != exp_c);
    err_next   = err_count;
    if (sample && mismatch && (err_count != '1)) begin
      err_next = err_count + 1'b1;
    end
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (sample && last_vec) state_next = DONE;
      DONE:    if (start) state_next = RUN;
      default: state_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Vector sequencing, response checking and result registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx            <= '0;
      hold           <= '0;
      bus.a_o        <= 1'b0;
      bus.b_o        <= 1'b0;
      bus.cin_o      <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= '0;
      fail_valid     <= 1'b0;
      first_fail_idx <= '0;
    end else if (accept) begin
      idx            <= '0;
      hold           <= '0;
      bus.a_o        <= 1'b0;
      bus.b_o        <= 1'b0;
      bus.cin_o      <= 1'b0;
      busy           <= 1'b1;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= '0;
      fail_valid     <= 1'b0;
      first_fail_idx <= '0;
    end else if (sample) begin
      // The sampling edge also launches the next vector, so no dead cycle
      // sits between vectors.
      err_count <= err_next;
      hold      <= '0;
      if (mismatch && !fail_valid) begin
        fail_valid     <= 1'b1;
        first_fail_idx <= idx;
      end
      if (last_vec) begin
        idx       <= '0;
        bus.a_o   <= 1'b0;
        bus.b_o   <= 1'b0;
        bus.cin_o <= 1'b0;
        busy      <= 1'b0;
        done      <= 1'b1;
        pass      <= (err_next == '0);
      end else begin
        idx <= idx + 3'd1;
        {bus.a_o, bus.b_o, bus.cin_o} <= idx + 3'd1;
      end
    end else if (state == RUN) begin
      hold <= hold + 4'd1;
    end
  end

endmodule

// File: tb/tb_fa_vector_checker.sv
// Scoreboard bench for fa_vector_checker: two instances (SETTLE=2/ERR_W=4
// and SETTLE=1/ERR_W=2) drive a behavioural adder whose sum/carry can be
// corrupted per vector by mask bytes.
module tb_fa_vector_checker;

  typedef struct {
    int inst;
    int done_at;
    int err;
    int fv;
    int ffi;
    int pass;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  int s_v[2]   = '{2, 1};
  int emax_v[2] = '{15, 3};

  logic       rst_v[2];
  logic       start_v[2];
  logic       busy_v[2];
  logic       done_v[2];
  logic       pass_v[2];
  logic       fv_v[2];
  logic [2:0] ffi_v[2];
  logic [2:0] ops_v[2];
  logic [7:0] fs_v[2];
  logic [7:0] fc_v[2];
  logic [3:0] err0;
  logic [1:0] err1;
  logic [1:0] sum0;
  logic [1:0] sum1;

  int   acc_at[2];
  logic active[2];
  logic done_q[2];
  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;

  fa_vector_checker_if bus0 ();
  fa_vector_checker_if bus1 ();

  // Behavioural adder under test with optional per-vector corruption
  assign ops_v[0]    = {bus0.a_o, bus0.b_o, bus0.cin_o};
  assign ops_v[1]    = {bus1.a_o, bus1.b_o, bus1.cin_o};
  assign sum0        = 2'(bus0.a_o) + 2'(bus0.b_o) + 2'(bus0.cin_o);
  assign sum1        = 2'(bus1.a_o) + 2'(bus1.b_o) + 2'(bus1.cin_o);
  assign bus0.s_i    = sum0[0] ^ fs_v[0][ops_v[0]];
  assign bus0.cout_i = sum0[1] ^ fc_v[0][ops_v[0]];
  assign bus1.s_i    = sum1[0] ^ fs_v[1][ops_v[1]];
  assign bus1.cout_i = sum1[1] ^ fc_v[1][ops_v[1]];

  fa_vector_checker #(.SETTLE_CYCLES(2), .ERR_W(4)) dut0 (
    .clk(clk), .rst_n(rst_v[0]), .start(start_v[0]), .bus(bus0.master),
    .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]), .err_count(err0),
    .fail_valid(fv_v[0]), .first_fail_idx(ffi_v[0])
  );

  fa_vector_checker #(.SETTLE_CYCLES(1), .ERR_W(2)) dut1 (
    .clk(clk), .rst_n(rst_v[1]), .start(start_v[1]), .bus(bus1.master),
    .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]), .err_count(err1),
    .fail_valid(fv_v[1]), .first_fail_idx(ffi_v[1])
  );

  function automatic int err_of(input int i);
    return (i == 0) ? int'(err0) : int'(err1);
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: vector sequence while running, results when done rises
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (active[i]) begin
        int k;
        k = edge_n - acc_at[i];
        if (k < 8 * s_v[i]) begin
          chk("busy_in_run", int'(busy_v[i]), 1);
          chk("vector", int'(ops_v[i]), k / s_v[i]);
        end
      end
      if (done_v[i] && !done_q[i]) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 0, 1);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("done_inst", i, e.inst);
          chk("done_cycle", edge_n, e.done_at);
          chk("err_count", err_of(i), e.err);
          chk("fail_valid", int'(fv_v[i]), e.fv);
          chk("first_fail_idx", int'(ffi_v[i]), e.ffi);
          chk("pass", int'(pass_v[i]), e.pass);
          chk("busy_at_done", int'(busy_v[i]), 0);
          chk("ops_at_done", int'(ops_v[i]), 0);
        end
        active[i] = 1'b0;
      end
      done_q[i] = done_v[i];
    end
  end

  task automatic go(input int i, input logic [7:0] fs, input logic [7:0] fc);
    exp_t       e;
    logic [7:0] bad;
    int         cnt;
    int         first;
    int         found;
    cnt   = 0;
    first = 0;
    found = 0;
    bad   = fs | fc;
    for (int v = 0; v < 8; v++) begin
      if (bad[v]) begin
        cnt++;
        if (found == 0) begin
          first = v;
          found = 1;
        end
      end
    end
    fs_v[i]    = fs;
    fc_v[i]    = fc;
    start_v[i] = 1'b1;
    @(posedge clk);
    #1;
    start_v[i] = 1'b0;
    acc_at[i]  = edge_n;
    active[i]  = 1'b1;
    e.inst     = i;
    e.done_at  = edge_n + 8 * s_v[i];
    e.err      = (cnt > emax_v[i]) ? emax_v[i] : cnt;
    e.fv       = found;
    e.ffi      = first;
    e.pass     = (cnt == 0) ? 1 : 0;
    sb.push_back(e);
    chk("start_done_clr", int'(done_v[i]), 0);
    chk("start_err_clr", err_of(i), 0);
    chk("start_fv_clr", int'(fv_v[i]), 0);
    chk("start_busy", int'(busy_v[i]), 1);
  endtask

  task automatic wait_done(input int i);
    int n;
    n = 0;
    while (active[i] && n < 8 * s_v[i] + 20) begin
      @(negedge clk);
      n++;
    end
    if (active[i]) begin
      chk("done_timeout", int'(done_v[i]), 1);
      active[i] = 1'b0;
      sb.delete();
    end
  endtask

  task automatic wait_vec(input int i, input int v);
    int n;
    n = 0;
    @(negedge clk);
    while (int'(ops_v[i]) != v && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (int'(ops_v[i]) != v) chk("wait_vec_timeout", int'(ops_v[i]), v);
  endtask

  task automatic poke_start(input int i);
    start_v[i] = 1'b1;
    @(negedge clk);
    start_v[i] = 1'b0;
  endtask

  task automatic rand_runs(input int i, input int runs);
    logic [7:0] fs;
    logic [7:0] fc;
    for (int r = 0; r < runs; r++) begin
      fs = ($urandom_range(0, 1) == 1) ? 8'($urandom) : 8'h00;
      fc = ($urandom_range(0, 1) == 1) ? 8'($urandom) : 8'h00;
      go(i, fs, fc);
      wait_done(i);
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      rst_v[i]   = 1'b0;
      start_v[i] = 1'b0;
      fs_v[i]    = 8'h00;
      fc_v[i]    = 8'h00;
      active[i]  = 1'b0;
      done_q[i]  = 1'b0;
      acc_at[i]  = 0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_busy", int'(busy_v[i]), 0);
      chk("rst_done", int'(done_v[i]), 0);
      chk("rst_pass", int'(pass_v[i]), 0);
      chk("rst_err", err_of(i), 0);
      chk("rst_fv", int'(fv_v[i]), 0);
      chk("rst_ffi", int'(ffi_v[i]), 0);
      chk("rst_ops", int'(ops_v[i]), 0);
      rst_v[i] = 1'b1;
    end
    @(negedge clk);

    // Ideal adder, then carry stuck at 0 (indices 3,5,6,7 fail)
    go(0, 8'h00, 8'h00);
    wait_done(0);
    go(0, 8'h00, 8'hE8);
    wait_done(0);

    // start during RUN is ignored; start in DONE restarts
    go(0, 8'h00, 8'h00);
    wait_vec(0, 2);
    poke_start(0);
    wait_vec(0, 5);
    poke_start(0);
    wait_done(0);
    go(0, 8'h00, 8'h00);
    wait_done(0);

    // Reset mid-run while vector 4 is held; start is ignored under reset
    go(0, 8'h00, 8'hE8);
    wait_vec(0, 4);
    chk("partial_err", err_of(0), 1);
    active[0] = 1'b0;
    void'(sb.pop_back());
    rst_v[0]   = 1'b0;
    start_v[0] = 1'b1;
    @(posedge clk);
    #1;
    rst_v[0]   = 1'b1;
    start_v[0] = 1'b0;
    chk("midrst_busy", int'(busy_v[0]), 0);
    chk("midrst_ops", int'(ops_v[0]), 0);
    chk("midrst_err", err_of(0), 0);
    chk("midrst_fv", int'(fv_v[0]), 0);
    chk("midrst_done", int'(done_v[0]), 0);
    @(negedge clk);
    go(0, 8'h00, 8'h00);
    wait_done(0);
    rand_runs(0, 6);

    // SETTLE=1, ERR_W=2: sum inverted saturates at 3, then ideal
    go(1, 8'hFF, 8'h00);
    wait_done(1);
    go(1, 8'h00, 8'h00);
    wait_done(1);
    rand_runs(1, 6);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/fa_vector_checker.md
Name: fa_vector_checker

Overview:
Synthesizable self-checking stimulus/response engine for a one-bit full adder. It drives all eight {A,B,Cin} input combinations onto an adder under test and samples the returned S/Cout. Each response is compared against the internally computed expected sum and carry, and the block reports the error count, the first failing vector and a pass flag. It replaces simulation-only stimulus with a hardware-resident tester usable on the board.

Parameters:
SETTLE_CYCLES, 2, clock cycles each vector is held before the response is sampled; legal range 1..15
ERR_W, 4, width of the error counter; the counter saturates at 2^ERR_W-1

Ports:
clk  input  1  system clock, rising-edge
rst_n  input  1  synchronous active-low reset
start  input  1  single-cycle request to begin a run; honoured only in IDLE or DONE
a_o  output  1  A operand driven to the adder under test
b_o  output  1  B operand driven to the adder under test
cin_o  output  1  carry-in driven to the adder under test
s_i  input  1  sum returned by the adder under test
cout_i  input  1  carry-out returned by the adder under test
busy  output  1  high while a run is in progress
done  output  1  high from run completion until the next accepted start or reset
pass  output  1  valid while done; 1 when err_count==0
err_count  output  ERR_W  number of mismatching vectors, saturating
fail_valid  output  1  set when the first mismatch is recorded; held until the next accepted start or reset
first_fail_idx  output  3  vector index {A,B,Cin} of the first mismatch; valid when fail_valid=1

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n. rst_n=0 at a rising edge forces state IDLE.
- Reset values: a_o, b_o, cin_o, busy, done, pass, fail_valid = 0; err_count = 0; first_fail_idx = 0; vector index = 0; hold counter = 0.
- All outputs are registered.
- FSM states:
  - IDLE: outputs quiescent. start=1 moves to RUN, sets index=0, clears err_count, fail_valid and first_fail_idx, and drives vector 0 on the same edge.
  - RUN: busy=1. {a_o,b_o,cin_o} = index, with index counting 0..7 in binary order (000, 001, ..., 111).
  - DONE: done=1, busy=0, operand outputs return to 0. start=1 re-enters RUN with all results cleared, exactly as from IDLE.
- Timing in RUN:
  - Each vector is held for exactly SETTLE_CYCLES cycles.
  - s_i and cout_i are sampled on the final edge of the hold window. The next vector is launched on that same edge.
- Expected values: exp_s = a^b^cin; exp_c = (a&b)|(a&cin)|(b&cin).
- Mismatch handling: a mismatch is s_i!=exp_s or cout_i!=exp_c. One vector counts at most one error even if both bits are wrong. err_count increments by 1 and saturates at all-ones. On the first mismatch of a run, first_fail_idx takes the index and fail_valid is set.
- Completion:
  - The edge that samples vector 7 moves the FSM to DONE and sets done=1.
  - pass=(final err_count==0), and err_count reflects vector 7 on that same edge.
  - Run length: the first vector appears one edge after start, and done appears 8*SETTLE_CYCLES edges later.
- start while RUN: ignored, with no effect on index, counters or results.
- Reset mid-run: on the edge where rst_n is sampled low, all outputs take their reset values and partial results are discarded. start is ignored while rst_n=0.
- Out-of-range SETTLE_CYCLES: behaviour is undefined; the bench does not test it.

Test Plan:
1. Ideal adder model wired back, SETTLE_CYCLES=2, start pulse at cycle 0 -> vectors 000..111 each held 2 cycles; done=1 at cycle 17 (16 edges after the first vector); pass=1, err_count=0, fail_valid=0.
2. Model with cout stuck at 0 -> mismatches at indices 3, 5, 6, 7; err_count=4, first_fail_idx=3, fail_valid=1, pass=0.
3. Model with S inverted, ERR_W=2 -> 8 mismatches saturate err_count at 3; first_fail_idx=0, pass=0.
4. Ideal model; start re-pulsed at vectors 2 and 5 of a run -> run unaffected, done at the normal cycle, pass=1. Then start pulsed in DONE -> done drops, results clear, and a second full run gives pass=1.
5. Faulty model (cout stuck 0); rst_n driven low for 1 cycle while vector 4 is held -> on the next edge busy=0, a_o/b_o/cin_o=0, err_count=0, fail_valid=0. A following start with the ideal model completes with pass=1.
6. Ideal model, SETTLE_CYCLES=1 -> a new vector every cycle; done 8 edges after the first vector; pass=1.
